// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a power-of-two byte FIFO.
// Bytes are pushed over valid/ready and shifted out LSB-first at CLK_FREQ_HZ/BAUD clocks per bit.
module uart_tx_fifo #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [7:0]                         i_data,
  input  logic                               i_valid,
  output logic                               o_ready,
  output logic                               o_tx,
  output logic                               o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_level
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: CLK_FREQ_HZ/BAUD must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  typedef struct packed {
    state_e          st;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            tx;
  } tx_state_t;

  localparam tx_state_t TX_RST = '{st: IDLE, cnt: '0, bit_idx: '0, shift: '0, tx: 1'b1};

  // ---------------- FIFO ----------------
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [7:0]  rd_data;
  logic        full, empty, push, pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign push    = i_valid && !full;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_data;
  end

  // ---------------- serializer ----------------
  tx_state_t cur, nxt;
  logic      bit_end;

  assign bit_end = (cur.cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cur <= TX_RST;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    pop = 1'b0;
    case (cur.st)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          nxt.st    = START;
          nxt.shift = rd_data;
          nxt.cnt   = '0;
          nxt.tx    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          nxt.st      = DATA;
          nxt.cnt     = '0;
          nxt.bit_idx = '0;
          nxt.tx      = cur.shift[0];
        end else begin
          nxt.cnt = cur.cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          nxt.cnt = '0;
          if (cur.bit_idx == 3'd7) begin
            nxt.st = STOP;
            nxt.tx = 1'b1;
          end else begin
            nxt.bit_idx = cur.bit_idx + 3'd1;
            nxt.shift   = {1'b0, cur.shift[7:1]};
            nxt.tx      = cur.shift[1];
          end
        end else begin
          nxt.cnt = cur.cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          nxt.cnt = '0;
          // A waiting byte starts its frame with no idle gap.
          if (!empty) begin
            pop       = 1'b1;
            nxt.st    = START;
            nxt.shift = rd_data;
            nxt.tx    = 1'b0;
          end else begin
            nxt.st = IDLE;
          end
        end else begin
          nxt.cnt = cur.cnt + CW'(1);
        end
      end
      default: nxt = TX_RST;
    endcase
  end

  assign o_tx    = cur.tx;
  assign o_ready = !full;
  assign o_busy  = (cur.st != IDLE) || !empty;
  assign o_level = LW'(wr_ptr - rd_ptr);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at DIV=8, depth 4: timeline model of frames plus a line decoder.
module tb_uart_tx_fifo;

  localparam int DIV   = 8;
  localparam int DEPTH = 4;

  logic       clk, rstn;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready, o_tx, o_busy;
  logic [2:0] o_level;

  uart_tx_fifo #(.CLK_FREQ_HZ(8), .BAUD(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_tx(o_tx), .o_busy(o_busy), .o_level(o_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model: accepted bytes queue; a frame is a timeline of 10*DIV cycles.
  logic [7:0] mq[$];
  logic [7:0] mlog[$];
  logic       mact = 1'b0;
  int         mt = 0;
  logic [7:0] mbyte = '0;
  int         pre;
  logic       mpush;

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      mq.delete();
      mact = 1'b0;
      mt   = 0;
    end else begin
      pre   = mq.size();
      mpush = i_valid && (pre < DEPTH);
      if (mact) begin
        mt++;
        if (mt == 10*DIV) mact = 1'b0;
      end
      if (!mact && pre > 0) begin
        mbyte = mq.pop_front();
        mact  = 1'b1;
        mt    = 0;
      end
      if (mpush) begin
        mq.push_back(i_data);
        mlog.push_back(i_data);
      end
    end
  end

  function automatic logic exp_tx();
    int k;
    logic [7:0] sh;
    if (!mact) return 1'b1;
    k = mt / DIV;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    sh = mbyte >> (k - 1);
    return sh[0];
  endfunction

  initial forever begin
    @(negedge clk);
    check("tx",    32'(o_tx),    32'(exp_tx()));
    check("level", 32'(o_level), 32'(mq.size()));
    check("ready", 32'(o_ready), 32'(mq.size() < DEPTH));
    check("busy",  32'(o_busy),  32'(mact || mq.size() > 0));
  end

  // Independent line decoder sampling mid-bit.
  logic [7:0] dec[$];
  initial forever begin
    logic [7:0] b;
    @(negedge clk);
    if (rstn && o_tx === 1'b0) begin
      repeat (DIV/2) @(negedge clk);
      b = '0;
      for (int k = 0; k < 8; k++) begin
        repeat (DIV) @(negedge clk);
        b = {o_tx, b[7:1]};
      end
      repeat (DIV) @(negedge clk);
      check("stop_bit", 32'(o_tx), 32'd1);
      dec.push_back(b);
    end
  end

  int   falls[$];
  logic prev_tx = 1'b1;
  initial forever begin
    @(negedge clk);
    if (prev_tx && !o_tx) falls.push_back(cyc);
    prev_tx = o_tx;
  end

  task automatic send(input logic [7:0] b, input int lim);
    logic acc;
    int n;
    i_valid = 1'b1;
    i_data  = b;
    n = 0;
    do begin
      acc = o_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < lim);
    i_valid = 1'b0;
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int n;
    n = 0;
    while (o_busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(o_busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] frame55;
    logic [9:0] fsh;
    logic [7:0] lit[$];
    logic       r;
    int         n, lows, m;

    rstn = 1'b0; i_valid = 1'b0; i_data = '0;
    repeat (3) @(negedge clk);
    check("rst_tx",    32'(o_tx),    32'd1);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_busy",  32'(o_busy),  32'd0);
    check("rst_level", 32'(o_level), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Single byte 0x55: stop, data LSB-first, start.
    frame55 = 10'b1_01010101_0;
    send(8'h55, 4);
    check("t0_level", 32'(o_level), 32'd1);
    @(negedge clk);
    check("t1_tx",    32'(o_tx),    32'd0);
    check("t1_level", 32'(o_level), 32'd0);
    repeat (DIV/2) @(negedge clk);
    fsh = frame55;
    check("f55_bit0", 32'(o_tx), 32'(fsh[0]));
    for (int k = 1; k < 10; k++) begin
      repeat (DIV) @(negedge clk);
      fsh = frame55 >> k;
      check("f55_bit", 32'(o_tx), 32'(fsh[0]));
    end
    repeat (3) @(negedge clk);
    check("t80_busy", 32'(o_busy), 32'd1);
    @(negedge clk);
    check("t81_busy", 32'(o_busy), 32'd0);

    // Back-to-back frames.
    falls.delete();
    send(8'h00, 4);
    send(8'hFF, 4);
    wait_idle(400, "b2b_idle");
    check("b2b_falls", 32'(falls.size()), 32'd2);
    if (falls.size() >= 2) begin
      check("b2b_gap",   32'(falls[1] - falls[0]), 32'd80);
      check("b2b_total", 32'(cyc - falls[0]),      32'd160);
    end

    // Fill the FIFO, then a held push while full.
    for (int k = 1; k <= 5; k++) send(8'(k), 4);
    check("full_level", 32'(o_level), 32'd4);
    check("full_ready", 32'(o_ready), 32'd0);
    send(8'h06, 200);
    i_valid = 1'b1;
    i_data  = 8'hAA;
    repeat (20) begin
      check("ign_ready", 32'(o_ready), 32'd0);
      @(negedge clk);
    end
    i_valid = 1'b0;
    check("ign_level", 32'(o_level), 32'd4);
    wait_idle(1000, "full_idle");

    lit = '{8'h55, 8'h00, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    check("dir_count", 32'(dec.size()), 32'd9);
    m = (dec.size() < 9) ? dec.size() : 9;
    for (int i = 0; i < m; i++) check("dir_byte", 32'(dec[i]), 32'(lit[i]));

    // Randomized traffic; sender holds data until accepted.
    r = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!(i_valid && !r)) begin
        i_valid = ($urandom_range(0, 2) == 0);
        i_data  = 8'($urandom);
      end
      r = o_ready;
      @(negedge clk);
    end
    i_valid = 1'b0;
    wait_idle(2000, "rnd_idle");
    check("rnd_count", 32'(dec.size()), 32'(mlog.size()));
    m = (dec.size() < mlog.size()) ? dec.size() : mlog.size();
    for (int i = 0; i < m; i++) check("rnd_byte", 32'(dec[i]), 32'(mlog[i]));

    // Reset in the middle of data bit 3.
    falls.delete();
    send(8'h00, 4);
    send(8'h33, 4);
    send(8'h44, 4);
    n = 0;
    while (falls.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_frame_started", 32'(falls.size() > 0), 32'd1);
    if (falls.size() > 0) begin
      n = 0;
      while (cyc < falls[0] + 35 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    check("pre_rst_tx",    32'(o_tx),    32'd0);
    check("pre_rst_level", 32'(o_level), 32'd2);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_tx",    32'(o_tx),    32'd1);
    check("async_level", 32'(o_level), 32'd0);
    check("async_ready", 32'(o_ready), 32'd1);
    check("async_busy",  32'(o_busy),  32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (!o_tx) lows++;
    end
    check("post_rst_lows", 32'(lows),    32'd0);
    check("post_rst_busy", 32'(o_busy),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
